cache_refill_arb: RTL and testbench
===================================

# cache_refill_arb

Line-refill controller and arbiter between the instruction-side and data-side caches and the shared backing memory. It accepts miss requests from both caches and grants them round-robin. For a data-cache miss with a dirty victim it writes the 512-bit victim line back before refilling. It returns the refilled line to the winning requester and holds the pipeline stall while any miss is outstanding.

## Interface
- LINE_W, 512, cache line width in bits
- ADDR_W, 32, byte address width
- OFF_W, 6, line offset bits (log2(LINE_W/8))

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- i_dc_miss  in  1  data-cache miss request; level, held until o_dc_done
- i_dc_addr  in  ADDR_W  data-cache miss byte address
- i_dc_evict  in  1  dirty victim must be written back first
- i_dc_evict_addr  in  ADDR_W  victim byte address
- i_dc_evict_data  in  LINE_W  victim line data
- i_ic_miss  in  1  instruction-side miss request; level, held until o_ic_done
- i_ic_addr  in  ADDR_W  instruction miss byte address
- o_dc_done  out  1  one-cycle pulse: o_line valid for data cache
- o_ic_done  out  1  one-cycle pulse: o_line valid for instruction side
- o_line  out  LINE_W  registered refill line
- o_mem_req  out  1  memory transaction request
- o_mem_we  out  1  1 = line write (writeback), 0 = line read
- o_mem_addr  out  ADDR_W  line-aligned address, low OFF_W bits forced 0
- o_mem_wdata  out  LINE_W  writeback data
- i_mem_ack  in  1  memory completes the current transaction this cycle
- i_mem_rdata  in  LINE_W  read data, valid with i_mem_ack on reads
- o_stall  out  1  pipeline stall

## Operation
- The controller has four states: IDLE, WB, RD and DONE.
- IDLE: grant when at least one miss request is unmasked.
  - If only one requester is pending, it wins.
  - If both are pending, the winner is the requester not served last. The last_grant register resets to IC, so DC wins the first tie.
  - Grant latches the requester id and the aligned miss address.
  - For DC grants, i_dc_evict, the victim address and the victim data are also latched.
  - Next state on grant: WB if DC with evict, otherwise RD. last_grant updates on grant.
- WB: o_mem_req=1, o_mem_we=1, o_mem_addr=aligned victim address, o_mem_wdata=latched victim. On i_mem_ack go to RD.
- RD: o_mem_req=1, o_mem_we=0, o_mem_addr=aligned miss address. On i_mem_ack, capture i_mem_rdata into o_line and go to DONE.
- DONE: pulse o_dc_done or o_ic_done for exactly one cycle, then go to IDLE.
- Mask: in the single IDLE cycle after DONE, the just-served requester's miss input is ignored. This covers a request the cache has not yet dropped.
- o_stall = (state != IDLE) | i_dc_miss | i_ic_miss. This is combinational from the registered state and the raw requests.
- Request inputs are sampled only in IDLE. Changes to addr or evict inputs after grant are ignored.
- i_mem_ack while o_mem_req=0 is ignored. Each ack completes exactly one transaction.

## Timing
- Reset values:
  - state=IDLE, last_grant=IC.
  - o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_line=0.
  - o_dc_done=0, o_ic_done=0.
  - o_stall follows the raw miss inputs.
- Reset mid-transaction: return to IDLE immediately. No done pulse is issued and the outstanding memory transaction is abandoned.
- o_mem_* are registered.
  - Miss seen in IDLE at cycle 0 gives o_mem_req=1 at cycle 1.
  - o_mem_addr, o_mem_we and o_mem_wdata are stable while o_mem_req=1 within a state.
- WB ack at cycle k: o_mem_req stays 1 with read address and we=0 from cycle k+1, with no idle gap.
- RD ack at cycle k: o_line is valid and the done pulse occurs at cycle k+1. o_mem_req=0 at k+1. IDLE at k+2.
- Minimum refill latency: miss at cycle 0, ack at cycle 1, done at cycle 2. Each extra memory wait cycle adds one.
- Back-to-back: the earliest new grant is in the IDLE cycle at k+2. The other requester's miss is not masked there.
- Address alignment: o_mem_addr = {addr[ADDR_W-1:OFF_W], OFF_W'b0}.

## Test plan
- DC miss at 0x0000_1234, no evict, ack on 3rd request cycle:
  - o_mem_addr=0x0000_1200, we=0.
  - o_line=rdata, o_dc_done pulses once.
  - o_stall high from cycle 0 through the DONE cycle.
- DC miss at 0x0000_4040, evict victim 0x0000_8000 with data pattern A5…:
  - WB transaction addr=0x0000_8000, we=1, wdata=pattern.
  - Then RD at 0x0000_4040 starting the cycle after the WB ack.
- DC and IC miss asserted in the same cycle out of reset:
  - DC served first, then IC, with exactly one done pulse each.
  - A second simultaneous pair after that is served IC first? No: last_grant=IC after the IC service, so DC is served first again.
- Requester holds miss one cycle past done: no duplicate transaction is issued. The other pending requester is granted in that cycle.
- rst asserted while in WB with o_mem_req=1:
  - All outputs return to their reset values asynchronously. No done pulse is issued.
  - After release, a held DC miss restarts from WB.
- Spurious i_mem_ack in IDLE: no state change, no done pulse, o_line unchanged.

Source files
------------

// File: rtl/cache_refill_arb.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill_arb
// Purpose  : Line-refill controller for a split I/D cache pair sharing one
//            backing memory. Misses from both sides are granted round-robin.
//            A data-side miss with a dirty victim first writes the victim line
//            back, then refills. The refilled line is returned with a one-cycle
//            done pulse to the requester that won the grant.
// Ports    : clk, rst              - clock, asynchronous active-high reset
//            i_dc_*                - data-cache miss request, address, victim
//            i_ic_*                - instruction-side miss request, address
//            o_dc_done/o_ic_done   - one-cycle pulse, o_line valid
//            o_line                - registered refill line
//            o_mem_* / i_mem_*     - single-transaction line memory port
//            o_stall               - pipeline stall
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill_arb #(
    parameter int LINE_W = 512,
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_dc_miss,
    input  logic [ADDR_W-1:0] i_dc_addr,
    input  logic              i_dc_evict,
    input  logic [ADDR_W-1:0] i_dc_evict_addr,
    input  logic [LINE_W-1:0] i_dc_evict_data,
    input  logic              i_ic_miss,
    input  logic [ADDR_W-1:0] i_ic_addr,
    output logic              o_dc_done,
    output logic              o_ic_done,
    output logic [LINE_W-1:0] o_line,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [LINE_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [LINE_W-1:0] i_mem_rdata,
    output logic              o_stall
);

    // Keeps the line-number bits, clears the byte offset within the line.
    localparam logic [ADDR_W-1:0] c_line_mask = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_RD   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_last_dc;   // 1: last grant went to DC, 0: to IC
    logic              r_srv_dc;    // requester currently being served
    logic              r_mask_dc;   // ignore DC request for one IDLE cycle
    logic              r_mask_ic;   // ignore IC request for one IDLE cycle
    logic [ADDR_W-1:0] r_miss_addr; // aligned refill address, used after a writeback

    logic              w_dc_req;
    logic              w_ic_req;
    logic              w_pick_dc;
    logic [ADDR_W-1:0] w_dc_addr_al;
    logic [ADDR_W-1:0] w_ic_addr_al;
    logic [ADDR_W-1:0] w_ev_addr_al;

    // The just-served requester may still be holding its miss level in the
    // IDLE cycle after DONE; masking it prevents a duplicate refill.
    assign w_dc_req  = i_dc_miss & ~r_mask_dc;
    assign w_ic_req  = i_ic_miss & ~r_mask_ic;
    // On a tie the requester not served last wins.
    assign w_pick_dc = w_dc_req & (~w_ic_req | ~r_last_dc);

    assign w_dc_addr_al = i_dc_addr & c_line_mask;
    assign w_ic_addr_al = i_ic_addr & c_line_mask;
    assign w_ev_addr_al = i_dc_evict_addr & c_line_mask;

    assign o_stall = (r_state != ST_IDLE) | i_dc_miss | i_ic_miss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_dc   <= 1'b0;
            r_srv_dc    <= 1'b0;
            r_mask_dc   <= 1'b0;
            r_mask_ic   <= 1'b0;
            r_miss_addr <= '0;
            o_dc_done   <= 1'b0;
            o_ic_done   <= 1'b0;
            o_line      <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            // Done pulses and masks live for exactly one cycle.
            o_dc_done <= 1'b0;
            o_ic_done <= 1'b0;
            r_mask_dc <= 1'b0;
            r_mask_ic <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_dc_req || w_ic_req) begin
                        r_srv_dc  <= w_pick_dc;
                        r_last_dc <= w_pick_dc;
                        o_mem_req <= 1'b1;
                        if (w_pick_dc) begin
                            r_miss_addr <= w_dc_addr_al;
                            if (i_dc_evict) begin
                                r_state     <= ST_WB;
                                o_mem_we    <= 1'b1;
                                o_mem_addr  <= w_ev_addr_al;
                                o_mem_wdata <= i_dc_evict_data;
                            end else begin
                                r_state    <= ST_RD;
                                o_mem_we   <= 1'b0;
                                o_mem_addr <= w_dc_addr_al;
                            end
                        end else begin
                            r_miss_addr <= w_ic_addr_al;
                            r_state     <= ST_RD;
                            o_mem_we    <= 1'b0;
                            o_mem_addr  <= w_ic_addr_al;
                        end
                    end
                end

                ST_WB: begin
                    // Writeback done: roll straight into the refill read with
                    // o_mem_req held high, no idle gap.
                    if (i_mem_ack) begin
                        r_state    <= ST_RD;
                        o_mem_we   <= 1'b0;
                        o_mem_addr <= r_miss_addr;
                    end
                end

                ST_RD: begin
                    if (i_mem_ack) begin
                        r_state   <= ST_DONE;
                        o_line    <= i_mem_rdata;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_dc_done <= r_srv_dc;
                        o_ic_done <= ~r_srv_dc;
                    end
                end

                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_mask_dc <= r_srv_dc;
                    r_mask_ic <= ~r_srv_dc;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    o_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill_arb
// Purpose  : Directed self-checking bench for cache_refill_arb. Inputs are
//            driven and outputs sampled on the falling clock edge; "cycle n"
//            is the clock period following the n-th rising edge of a test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill_arb;

    localparam int LINE_W = 512;
    localparam int ADDR_W = 32;
    localparam int OFF_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_dc_miss;
    logic [ADDR_W-1:0] i_dc_addr;
    logic              i_dc_evict;
    logic [ADDR_W-1:0] i_dc_evict_addr;
    logic [LINE_W-1:0] i_dc_evict_data;
    logic              i_ic_miss;
    logic [ADDR_W-1:0] i_ic_addr;
    logic              o_dc_done;
    logic              o_ic_done;
    logic [LINE_W-1:0] o_line;
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [LINE_W-1:0] o_mem_wdata;
    logic              i_mem_ack;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              o_stall;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [LINE_W-1:0] c_pat_a  = {64{8'hA5}};
    localparam logic [LINE_W-1:0] c_pat_1  = {8{64'hDEAD_BEEF_0000_0001}};
    localparam logic [LINE_W-1:0] c_pat_r  = {16{32'h0F1E_2D3C}};
    localparam logic [LINE_W-1:0] c_pat_d  = {16{32'h1111_2222}};
    localparam logic [LINE_W-1:0] c_pat_i  = {16{32'h3333_4444}};
    localparam logic [LINE_W-1:0] c_pat_d2 = {16{32'h5555_6666}};
    localparam logic [LINE_W-1:0] c_pat_i2 = {16{32'h7777_8888}};
    localparam logic [LINE_W-1:0] c_pat_r2 = {16{32'h9999_AAAA}};
    localparam logic [LINE_W-1:0] c_junk   = {16{32'hBAD0_BAD0}};

    cache_refill_arb #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_dc_miss       (i_dc_miss),
        .i_dc_addr       (i_dc_addr),
        .i_dc_evict      (i_dc_evict),
        .i_dc_evict_addr (i_dc_evict_addr),
        .i_dc_evict_data (i_dc_evict_data),
        .i_ic_miss       (i_ic_miss),
        .i_ic_addr       (i_ic_addr),
        .o_dc_done       (o_dc_done),
        .o_ic_done       (o_ic_done),
        .o_line          (o_line),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .i_mem_ack       (i_mem_ack),
        .i_mem_rdata     (i_mem_rdata),
        .o_stall         (o_stall)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_cmp++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0h exp 0", o_mem_req); end
        n_cmp++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0h exp 0", o_mem_we); end
        n_cmp++; if (o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", o_mem_addr); end
        n_cmp++; if (o_mem_wdata !== '0) begin n_fail++; $display("FAIL rst_wdata: got %h exp 0", o_mem_wdata); end
        n_cmp++; if (o_line !== '0) begin n_fail++; $display("FAIL rst_line: got %h exp 0", o_line); end
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b00) begin n_fail++; $display("FAIL rst_done: got %b exp 00", {o_dc_done, o_ic_done}); end
        n_cmp++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_idle: got %0h exp 0", o_stall); end
        i_ic_miss = 1'b1;
        #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall_raw: got %0h exp 1", o_stall); end
        i_ic_miss = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_dc_refill();
        i_dc_miss = 1'b1; i_dc_addr = 32'h0000_1234; i_dc_evict = 1'b0;
        #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL dc_stall_c0: got %0h exp 1", o_stall); end
        cyc(); // cycle 1
        n_cmp++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL dc_req_c1: got %0h exp 1", o_mem_req); end
        n_cmp++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL dc_we_c1: got %0h exp 0", o_mem_we); end
        n_cmp++; if (o_mem_addr !== 32'h0000_1200) begin n_fail++; $display("FAIL dc_addr_c1: got %h exp 00001200", o_mem_addr); end
        cyc(); // cycle 2
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_1200) begin n_fail++; $display("FAIL dc_hold_c2: got req %0h addr %h exp 1 00001200", o_mem_req, o_mem_addr); end
        n_cmp++; if (o_dc_done !== 1'b0) begin n_fail++; $display("FAIL dc_early_done: got %0h exp 0", o_dc_done); end
        cyc(); // cycle 3: third request cycle, memory acks
        n_cmp++; if (o_mem_req !== 1'b1) begin n_fail++; $display("FAIL dc_req_c3: got %0h exp 1", o_mem_req); end
        i_mem_ack = 1'b1; i_mem_rdata = c_pat_1;
        cyc(); // cycle 4: DONE
        i_mem_ack = 1'b0; i_mem_rdata = c_junk;
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b10) begin n_fail++; $display("FAIL dc_done_c4: got %b exp 10", {o_dc_done, o_ic_done}); end
        n_cmp++; if (o_line !== c_pat_1) begin n_fail++; $display("FAIL dc_line_c4: got %h exp %h", o_line, c_pat_1); end
        n_cmp++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL dc_req_c4: got %0h exp 0", o_mem_req); end
        i_dc_miss = 1'b0;
        #1;
        n_cmp++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL dc_stall_done: got %0h exp 1", o_stall); end
        cyc(); // cycle 5: IDLE
        n_cmp++; if (o_dc_done !== 1'b0) begin n_fail++; $display("FAIL dc_done_c5: got %0h exp 0", o_dc_done); end
        n_cmp++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL dc_stall_c5: got %0h exp 0", o_stall); end
        n_cmp++; if (o_line !== c_pat_1) begin n_fail++; $display("FAIL dc_line_c5: got %h exp %h", o_line, c_pat_1); end
        cyc();
    endtask

    task automatic test_evict();
        i_dc_miss = 1'b1; i_dc_addr = 32'h0000_4040; i_dc_evict = 1'b1;
        i_dc_evict_addr = 32'h0000_8000; i_dc_evict_data = c_pat_a;
        cyc(); // cycle 1: WB
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1) begin n_fail++; $display("FAIL wb_req_we: got %0h%0h exp 11", o_mem_req, o_mem_we); end
        n_cmp++; if (o_mem_addr !== 32'h0000_8000) begin n_fail++; $display("FAIL wb_addr: got %h exp 00008000", o_mem_addr); end
        n_cmp++; if (o_mem_wdata !== c_pat_a) begin n_fail++; $display("FAIL wb_wdata: got %h exp %h", o_mem_wdata, c_pat_a); end
        // Post-grant input changes must not leak into the transaction.
        i_dc_addr = 32'h0000_7777; i_dc_evict = 1'b0;
        i_dc_evict_addr = 32'h0000_FFC0; i_dc_evict_data = c_junk;
        i_mem_ack = 1'b1; i_mem_rdata = c_pat_r;
        cyc(); // cycle 2: RD, ack held so this cycle's ack completes the read
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_req_we: got %0h%0h exp 10", o_mem_req, o_mem_we); end
        n_cmp++; if (o_mem_addr !== 32'h0000_4040) begin n_fail++; $display("FAIL rd_addr: got %h exp 00004040", o_mem_addr); end
        n_cmp++; if (o_dc_done !== 1'b0) begin n_fail++; $display("FAIL ev_early_done: got %0h exp 0", o_dc_done); end
        cyc(); // cycle 3: DONE
        i_mem_ack = 1'b0;
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b10) begin n_fail++; $display("FAIL ev_done: got %b exp 10", {o_dc_done, o_ic_done}); end
        n_cmp++; if (o_line !== c_pat_r) begin n_fail++; $display("FAIL ev_line: got %h exp %h", o_line, c_pat_r); end
        i_dc_miss = 1'b0; i_dc_evict = 1'b0;
        cyc();
        n_cmp++; if (o_mem_req !== 1'b0 || o_dc_done !== 1'b0) begin n_fail++; $display("FAIL ev_idle: got req %0h done %0h exp 0 0", o_mem_req, o_dc_done); end
        cyc();
    endtask

    task automatic test_back_to_back();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        i_dc_miss = 1'b1; i_dc_addr = 32'h0000_1000; i_dc_evict = 1'b0;
        i_ic_miss = 1'b1; i_ic_addr = 32'h0000_2040;
        cyc(); // cycle 1: DC wins first tie
        n_cmp++; if (o_mem_addr !== 32'h0000_1000 || o_mem_req !== 1'b1) begin n_fail++; $display("FAIL tie1_dc_first: got req %0h addr %h exp 1 00001000", o_mem_req, o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = c_pat_d;
        cyc(); // cycle 2: DONE for DC, DC keeps miss high
        i_mem_ack = 1'b0;
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b10 || o_line !== c_pat_d) begin n_fail++; $display("FAIL tie1_dc_done: got %b line %h exp 10 %h", {o_dc_done, o_ic_done}, o_line, c_pat_d); end
        cyc(); // cycle 3: IDLE, DC masked, IC granted
        n_cmp++; if (o_mem_req !== 1'b0 || {o_dc_done, o_ic_done} !== 2'b00) begin n_fail++; $display("FAIL tie1_idle: got req %0h done %b exp 0 00", o_mem_req, {o_dc_done, o_ic_done}); end
        i_dc_miss = 1'b0;
        cyc(); // cycle 4: IC read, no duplicate DC read
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_2040 || o_mem_we !== 1'b0) begin n_fail++; $display("FAIL tie1_ic_rd: got req %0h we %0h addr %h exp 1 0 00002040", o_mem_req, o_mem_we, o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = c_pat_i;
        cyc(); // cycle 5: IC DONE
        i_mem_ack = 1'b0;
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b01 || o_line !== c_pat_i) begin n_fail++; $display("FAIL tie1_ic_done: got %b line %h exp 01 %h", {o_dc_done, o_ic_done}, o_line, c_pat_i); end
        i_ic_miss = 1'b0;
        cyc(); // cycle 6
        n_cmp++; if (o_mem_req !== 1'b0 || {o_dc_done, o_ic_done} !== 2'b00) begin n_fail++; $display("FAIL tie1_quiet: got req %0h done %b exp 0 00", o_mem_req, {o_dc_done, o_ic_done}); end
        cyc(); // cycle 7: second simultaneous pair
        i_dc_miss = 1'b1; i_dc_addr = 32'h0000_3000;
        i_ic_miss = 1'b1; i_ic_addr = 32'h0000_5080;
        cyc(); // cycle 8: last grant was IC, so DC again
        n_cmp++; if (o_mem_addr !== 32'h0000_3000 || o_mem_req !== 1'b1) begin n_fail++; $display("FAIL tie2_dc_first: got req %0h addr %h exp 1 00003000", o_mem_req, o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = c_pat_d2;
        cyc(); // cycle 9
        i_mem_ack = 1'b0;
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b10 || o_line !== c_pat_d2) begin n_fail++; $display("FAIL tie2_dc_done: got %b line %h exp 10 %h", {o_dc_done, o_ic_done}, o_line, c_pat_d2); end
        i_dc_miss = 1'b0;
        cyc(); // cycle 10: IDLE, IC granted (not masked)
        n_cmp++; if (o_mem_req !== 1'b0) begin n_fail++; $display("FAIL tie2_idle: got req %0h exp 0", o_mem_req); end
        cyc(); // cycle 11
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h0000_5080) begin n_fail++; $display("FAIL tie2_ic_rd: got req %0h addr %h exp 1 00005080", o_mem_req, o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = c_pat_i2;
        cyc(); // cycle 12
        i_mem_ack = 1'b0;
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b01 || o_line !== c_pat_i2) begin n_fail++; $display("FAIL tie2_ic_done: got %b line %h exp 01 %h", {o_dc_done, o_ic_done}, o_line, c_pat_i2); end
        i_ic_miss = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_reset_in_wb();
        i_dc_miss = 1'b1; i_dc_addr = 32'h0000_6000; i_dc_evict = 1'b1;
        i_dc_evict_addr = 32'h0000_9000; i_dc_evict_data = c_pat_a;
        cyc(); // cycle 1: WB
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 32'h0000_9000) begin n_fail++; $display("FAIL rwb_pre: got req %0h we %0h addr %h exp 1 1 00009000", o_mem_req, o_mem_we, o_mem_addr); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (o_mem_req !== 1'b0 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h0) begin n_fail++; $display("FAIL rwb_async: got req %0h we %0h addr %h exp 0 0 0", o_mem_req, o_mem_we, o_mem_addr); end
        n_cmp++; if (o_mem_wdata !== '0 || o_line !== '0) begin n_fail++; $display("FAIL rwb_data: got wdata %h line %h exp 0 0", o_mem_wdata, o_line); end
        n_cmp++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL rwb_stall: got %0h exp 1", o_stall); end
        cyc(); // still in reset
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b00 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL rwb_held: got done %b req %0h exp 00 0", {o_dc_done, o_ic_done}, o_mem_req); end
        rst = 1'b0;
        cyc(); // restart from WB
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b1 || o_mem_addr !== 32'h0000_9000 || o_mem_wdata !== c_pat_a) begin n_fail++; $display("FAIL rwb_restart: got req %0h we %0h addr %h exp 1 1 00009000", o_mem_req, o_mem_we, o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = c_pat_r2;
        cyc();
        n_cmp++; if (o_mem_req !== 1'b1 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h0000_6000) begin n_fail++; $display("FAIL rwb_rd: got req %0h we %0h addr %h exp 1 0 00006000", o_mem_req, o_mem_we, o_mem_addr); end
        cyc();
        i_mem_ack = 1'b0;
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b10 || o_line !== c_pat_r2) begin n_fail++; $display("FAIL rwb_done: got %b line %h exp 10 %h", {o_dc_done, o_ic_done}, o_line, c_pat_r2); end
        i_dc_miss = 1'b0; i_dc_evict = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_spurious_ack();
        i_mem_ack = 1'b1; i_mem_rdata = c_junk;
        cyc();
        i_mem_ack = 1'b0;
        n_cmp++; if (o_mem_req !== 1'b0 || {o_dc_done, o_ic_done} !== 2'b00) begin n_fail++; $display("FAIL spur_state: got req %0h done %b exp 0 00", o_mem_req, {o_dc_done, o_ic_done}); end
        n_cmp++; if (o_line !== c_pat_r2) begin n_fail++; $display("FAIL spur_line: got %h exp %h", o_line, c_pat_r2); end
        n_cmp++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL spur_stall: got %0h exp 0", o_stall); end
        cyc();
        n_cmp++; if ({o_dc_done, o_ic_done} !== 2'b00 || o_mem_req !== 1'b0) begin n_fail++; $display("FAIL spur_after: got done %b req %0h exp 00 0", {o_dc_done, o_ic_done}, o_mem_req); end
    endtask

    initial begin
        rst = 1'b1;
        i_dc_miss = 1'b0; i_dc_addr = '0; i_dc_evict = 1'b0;
        i_dc_evict_addr = '0; i_dc_evict_data = '0;
        i_ic_miss = 1'b0; i_ic_addr = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        test_reset();
        test_dc_refill();
        test_evict();
        test_back_to_back();
        test_reset_in_wb();
        test_spurious_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
